// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run controller: reset polarity and FSM state codes.
// State codes are visible on state_o, so their values are part of the interface.
package run_ctrl_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable; sticks at all-ones instead of wrapping.
// Clear has priority over enable; the count is registered.
module run_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Reset sequencer and run-window gate: hold all channels in reset, release them
// staggered, then run until halt request or cycle budget; all outputs registered.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 50,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              halt_req_i,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              run_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [2:0]        state_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(STAGGER * (NUM_CH - 1));
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
    localparam logic             TIMEOUT_EN = (RUN_CYCLES != 0);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  phase_inc;
    logic [CNT_W-1:0]  rel_elapsed;
    logic [CNT_W-1:0]  run_cnt;
    logic              phase_clr;
    logic              run_clr;
    logic [NUM_CH-1:0] rel_hit;

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (phase_cnt == HOLD_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (phase_cnt == REL_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (TIMEOUT_EN && (run_cnt == RUN_LAST)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_HOLD;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        run_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Phase counter: cycles completed in the current HOLD or RELEASE visit.
    assign phase_clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign phase_inc = phase_cnt + CNT_W'(1);

    run_ctrl_sat_counter #(.W(CNT_W)) u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (phase_clr),
        .en_i  (1'b1),
        .cnt_o (phase_cnt)
    );

    assign run_clr = ((state_q == ST_RELEASE) && (state_d == ST_RUN)) ||
                     ((state_q == ST_DONE) && start_i);

    run_ctrl_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (run_clr),
        .en_i  (state_q == ST_RUN),
        .cnt_o (run_cnt)
    );

    // Cycles since RELEASE entry as of the coming edge; zero on the entry edge itself.
    assign rel_elapsed = (state_q == ST_RELEASE) ? phase_inc : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
        localparam logic [CNT_W-1:0] REL_AT = CNT_W'(STAGGER * k);
        assign rel_hit[k] = (rel_elapsed >= REL_AT);
    end

    always_comb begin
        ch_rst_d = {NUM_CH{RST_ENABLE}};
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            ch_rst_d = ch_rst_q;
        end else if ((state_d == ST_RELEASE) || (state_d == ST_RUN)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_rst_d[k] = rel_hit[k] ? RST_DISABLE : RST_ENABLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_rst_q  <= {NUM_CH{RST_ENABLE}};
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_rst_q  <= ch_rst_d;
            run_q     <= run_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign ch_rst_o    = ch_rst_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = run_cnt;
    assign state_o     = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed vector table, a corner-parameter sequence, and random
// stimulus against a timeline model (age since HOLD entry) on two instances.
module tb_run_ctrl;

    typedef struct {
        int n, h, s, rc, w;
    } cfg_t;

    typedef struct {
        bit busy, done, tmo;
        int age, cnt;
    } mdl_t;

    typedef struct {
        bit r, s, h;
        int n;
        int st, ch;
        bit run, done, tmo;
        int cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        d_rst, d_start, d_halt;
    logic [3:0]  d_ch;
    logic        d_run, d_done, d_tmo;
    logic [15:0] d_cnt;
    logic [2:0]  d_st;

    logic        c_rst, c_start, c_halt;
    logic [0:0]  c_ch;
    logic        c_run, c_done, c_tmo;
    logic [3:0]  c_cnt;
    logic [2:0]  c_st;

    run_ctrl dut (
        .clk(clk), .rst(d_rst), .start_i(d_start), .halt_req_i(d_halt),
        .ch_rst_o(d_ch), .run_o(d_run), .done_o(d_done), .timeout_o(d_tmo),
        .cycle_cnt_o(d_cnt), .state_o(d_st)
    );

    run_ctrl #(.NUM_CH(1), .HOLD_CYCLES(10), .STAGGER(0), .RUN_CYCLES(0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(c_rst), .start_i(c_start), .halt_req_i(c_halt),
        .ch_rst_o(c_ch), .run_o(c_run), .done_o(c_done), .timeout_o(c_tmo),
        .cycle_cnt_o(c_cnt), .state_o(c_st)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    cfg_t cfg_d, cfg_c;
    mdl_t m_d, m_c;
    vec_t tbl[$];

    function automatic int run_start(cfg_t c);
        return c.h + c.s * (c.n - 1) + 1;
    endfunction

    // One clock edge of the reference timeline, given the inputs sampled at that edge.
    function automatic mdl_t mdl_step(cfg_t c, mdl_t m, bit r, bit s, bit h);
        mdl_t o = m;
        int   sat = (1 << c.w) - 1;
        if (r) begin
            o.busy = 0; o.done = 0; o.tmo = 0; o.cnt = 0; o.age = 0;
            return o;
        end
        if (!o.busy) begin
            if (s) begin
                o.busy = 1; o.done = 0; o.tmo = 0; o.cnt = 0; o.age = 0;
            end
            return o;
        end
        if (o.age >= run_start(c)) begin
            o.cnt = (o.cnt < sat) ? o.cnt + 1 : sat;
            if (h) begin
                o.busy = 0; o.done = 1; o.tmo = 0;
            end else if (c.rc != 0 && o.cnt == c.rc) begin
                o.busy = 0; o.done = 1; o.tmo = 1;
            end
        end
        o.age = o.age + 1;
        return o;
    endfunction

    function automatic int exp_state(cfg_t c, mdl_t m);
        if (!m.busy) return m.done ? 4 : 0;
        if (m.age < c.h) return 1;
        if (m.age < run_start(c)) return 2;
        return 3;
    endfunction

    function automatic int exp_ch(cfg_t c, mdl_t m);
        int mask = 0;
        for (int k = 0; k < c.n; k++)
            if (!(m.busy && m.age >= c.h + c.s * k)) mask |= (1 << k);
        return mask;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("d.state", int'(d_st), exp_state(cfg_d, m_d));
        chk("d.ch_rst", int'(d_ch), exp_ch(cfg_d, m_d));
        chk("d.run", int'(d_run), int'(exp_state(cfg_d, m_d) == 3));
        chk("d.done", int'(d_done), int'(m_d.done && !m_d.busy));
        chk("d.timeout", int'(d_tmo), int'(m_d.tmo));
        chk("d.cnt", int'(d_cnt), m_d.cnt);
        chk("c.state", int'(c_st), exp_state(cfg_c, m_c));
        chk("c.ch_rst", int'(c_ch), exp_ch(cfg_c, m_c));
        chk("c.run", int'(c_run), int'(exp_state(cfg_c, m_c) == 3));
        chk("c.done", int'(c_done), int'(m_c.done && !m_c.busy));
        chk("c.timeout", int'(c_tmo), int'(m_c.tmo));
        chk("c.cnt", int'(c_cnt), m_c.cnt);
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked at the same point.
    task automatic cycle(bit dr, bit ds, bit dh, bit cr, bit cs, bit chl);
        d_rst = dr; d_start = ds; d_halt = dh;
        c_rst = cr; c_start = cs; c_halt = chl;
        @(posedge clk);
        m_d = mdl_step(cfg_d, m_d, dr, ds, dh);
        m_c = mdl_step(cfg_c, m_c, cr, cs, chl);
        #1;
        chk_model();
    endtask

    function automatic vec_t v(bit r, bit s, bit h, int n, int st, int ch,
                               bit run, bit done, bit tmo, int cnt);
        vec_t x;
        x.r = r; x.s = s; x.h = h; x.n = n; x.st = st; x.ch = ch;
        x.run = run; x.done = done; x.tmo = tmo; x.cnt = cnt;
        return x;
    endfunction

    initial begin
        cfg_d = '{n: 4, h: 10, s: 2, rc: 50, w: 16};
        cfg_c = '{n: 1, h: 10, s: 0, rc: 0, w: 4};
        m_d = '{busy: 0, done: 0, tmo: 0, age: 0, cnt: 0};
        m_c = m_d;
        d_rst = 1; d_start = 0; d_halt = 0;
        c_rst = 1; c_start = 0; c_halt = 0;

        //           r  s  h   n  st  ch  run done tmo cnt
        tbl.push_back(v(1, 1, 1,  5, 0, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  1, 0, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 1, 0,  1, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  9, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  1, 2, 14, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  2, 2, 12, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  2, 2,  8, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  2, 2,  0, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  1, 3,  0, 1, 0, 0,  0));
        tbl.push_back(v(0, 0, 0, 49, 3,  0, 1, 0, 0, 49));
        tbl.push_back(v(0, 0, 0,  1, 4, 15, 0, 1, 1, 50));
        tbl.push_back(v(0, 0, 1,  3, 4, 15, 0, 1, 1, 50));
        tbl.push_back(v(0, 1, 0,  1, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 1, 1,  3, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  7, 2, 14, 0, 0, 0,  0));
        tbl.push_back(v(1, 0, 0,  1, 0, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 1, 0,  1, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0, 17, 3,  0, 1, 0, 0,  0));
        tbl.push_back(v(0, 0, 0,  4, 3,  0, 1, 0, 0,  4));
        tbl.push_back(v(0, 0, 1,  1, 4, 15, 0, 1, 0,  5));
        tbl.push_back(v(0, 1, 0,  1, 1, 15, 0, 0, 0,  0));
        tbl.push_back(v(0, 0, 0, 17, 3,  0, 1, 0, 0,  0));
        tbl.push_back(v(0, 1, 0, 49, 3,  0, 1, 0, 0, 49));
        tbl.push_back(v(0, 0, 1,  1, 4, 15, 0, 1, 0, 50));

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++)
                cycle(tbl[i].r, tbl[i].s, tbl[i].h, 1'b1, 1'b0, 1'b0);
            chk($sformatf("row%0d.state", i), int'(d_st), tbl[i].st);
            chk($sformatf("row%0d.ch_rst", i), int'(d_ch), tbl[i].ch);
            chk($sformatf("row%0d.run", i), int'(d_run), int'(tbl[i].run));
            chk($sformatf("row%0d.done", i), int'(d_done), int'(tbl[i].done));
            chk($sformatf("row%0d.timeout", i), int'(d_tmo), int'(tbl[i].tmo));
            chk($sformatf("row%0d.cnt", i), int'(d_cnt), tbl[i].cnt);
        end

        // Corner instance: single channel, no stagger, no timeout, 4-bit counter.
        cycle(0, 0, 0, 0, 1, 0);
        chk("corner.hold", int'(c_st), 1);
        repeat (9) cycle(0, 0, 0, 0, 0, 0);
        chk("corner.hold_end", int'(c_st), 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("corner.release", int'(c_st), 2);
        chk("corner.release_ch", int'(c_ch), 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("corner.run_after_1", int'(c_st), 3);
        chk("corner.run_cnt0", int'(c_cnt), 0);
        repeat (20) cycle(0, 0, 0, 0, 0, 0);
        chk("corner.saturated", int'(c_cnt), 15);
        chk("corner.still_run", int'(c_run), 1);
        chk("corner.no_timeout", int'(c_tmo), 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("corner.halt_state", int'(c_st), 4);
        chk("corner.halt_cnt", int'(c_cnt), 15);
        chk("corner.halt_tmo", int'(c_tmo), 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(149) == 0, $urandom_range(19) == 0, $urandom_range(39) == 0,
                  $urandom_range(149) == 0, $urandom_range(19) == 0, $urandom_range(39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
